ps2_scan_receiver: RTL and testbench

- Next-generation PS/2 keyboard receiver, fully synchronous to the system clock.
- Oversamples PS2Clk/PS2Data and assembles 11-bit frames with parity, stop-bit and timeout checks.
- Folds F0 (break) and E0 (extended) prefixes into one key event, then buffers events in a parametrised FIFO with valid/ready handshake.
- Sits between the PS/2 pins and the display/decode logic; replaces the PS2Clk-clocked receiver.

---
 rtl/ps2_scan_receiver.sv | 186 ++++++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver on the system clock: frame assembly, break/extended prefix folding, event FIFO.
// Optional build macro PS2_EXTENDED_EN folds E0 prefixes into keyExt; without it E0 is an ordinary code.
module ps2_scan_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               PS2Clk,
  input  logic                               PS2Data,
  output logic [7:0]                         keyCode,
  output logic                               keyBreak,
  output logic                               keyExt,
  output logic                               keyValid,
  input  logic                               keyReady,
  output logic                               parityErr,
  output logic                               frameErr,
  output logic                               overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifoCount
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
`ifdef PS2_EXTENDED_EN
  localparam int EW = 10;
`else
  localparam int EW = 9;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev, ps2_fall, ps2_bit;
  logic [7:0]             shift_reg, byte_q;
  logic [2:0]             bit_cnt;
  logic                   par_bit, byte_good;
  logic [TW-1:0]          idle_cnt;
  logic                   start_en, shift_en, par_en, frame_end, timeout, parity_ok, flag_clear;
  logic                   break_pend;

  // Pins idle high, so the synchronisers reset to 1 to avoid a false falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2Clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], PS2Data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign ps2_fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign ps2_bit  = data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = IDLE;
    end else if (ps2_fall) begin
      case (state)
        IDLE:    if (!ps2_bit) state_next = DATA;
        DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    start_en  = ps2_fall && (state == IDLE) && !ps2_bit;
    shift_en  = ps2_fall && (state == DATA);
    par_en    = ps2_fall && (state == PARITY);
    frame_end = ps2_fall && (state == STOP);
    timeout   = (state != IDLE) && !ps2_fall && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    parity_ok = ^{shift_reg, par_bit};
  end

  // Bad parity takes precedence over a bad stop bit when both fail.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      byte_q    <= '0;
      bit_cnt   <= '0;
      par_bit   <= 1'b0;
      idle_cnt  <= '0;
      byte_good <= 1'b0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      byte_good <= 1'b0;
      parityErr <= 1'b0;
      frameErr  <= timeout;
      if (ps2_fall)            idle_cnt <= '0;
      else if (state != IDLE)  idle_cnt <= idle_cnt + 1'b1;
      if (start_en) bit_cnt <= '0;
      if (shift_en) begin
        shift_reg <= {ps2_bit, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
      if (par_en) par_bit <= ps2_bit;
      if (frame_end) begin
        parityErr <= !parity_ok;
        frameErr  <= parity_ok && !ps2_bit;
        byte_good <= parity_ok && ps2_bit;
        byte_q    <= shift_reg;
      end
    end
  end

  assign flag_clear = (frame_end && !(parity_ok && ps2_bit)) || timeout;

  logic          push_req, push, pop, full;
  logic [EW-1:0] entry;

`ifdef PS2_EXTENDED_EN
  logic ext_pend;
  always_ff @(posedge clk) begin
    if (reset || flag_clear) ext_pend <= 1'b0;
    else if (byte_good)      ext_pend <= (byte_q == 8'hE0) || (ext_pend && byte_q == 8'hF0);
  end
  assign push_req = byte_good && (byte_q != 8'hF0) && (byte_q != 8'hE0);
  assign entry    = {ext_pend, break_pend, byte_q};
`else
  assign push_req = byte_good && (byte_q != 8'hF0);
  assign entry    = {break_pend, byte_q};
`endif

  // A prefix only survives until the next non-prefix byte or any dropped frame.
  always_ff @(posedge clk) begin
    if (reset || flag_clear) break_pend <= 1'b0;
    else if (byte_good)      break_pend <= (byte_q == 8'hF0);
  end

  // Handshake: the head entry transfers on any cycle where keyValid and keyReady are both high;
  // keyValid never depends on keyReady and the head is stable until it is taken.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] head;

  assign keyValid = (count != '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = keyValid && keyReady;
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign keyCode   = keyValid ? head[7:0] : 8'h00;
  assign keyBreak  = keyValid & head[8];
`ifdef PS2_EXTENDED_EN
  assign keyExt    = keyValid & head[9];
`else
  assign keyExt    = 1'b0;
`endif
  assign fifoCount = count;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench for ps2_scan_receiver: PS/2 frame driver, expected-event queue, error pulse checks.
module tb_ps2_scan_receiver;

  localparam int SYNC_STAGES    = 2;
  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int CW             = $clog2(FIFO_DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, PS2Clk, PS2Data, keyReady;
  logic [7:0]    keyCode;
  logic          keyBreak, keyExt, keyValid, parityErr, frameErr, overflow;
  logic [CW-1:0] fifoCount;

  ps2_scan_receiver #(
    .SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .PS2Clk(PS2Clk), .PS2Data(PS2Data),
    .keyCode(keyCode), .keyBreak(keyBreak), .keyExt(keyExt), .keyValid(keyValid),
    .keyReady(keyReady), .parityErr(parityErr), .frameErr(frameErr),
    .overflow(overflow), .fifoCount(fifoCount)
  );

  // clock / reset
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard state
  logic [9:0]  exp_q[$];
  bit          m_brk = 0, m_ext = 0, m_ovf = 0;
  int unsigned fall_cyc = 0, kv_rise_cyc = 0, fe_cyc = 0;
  int          kv_len = 0, pe_cnt = 0, fe_cnt = 0;
  bit          kv_prev = 0, stop_seen = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (parityErr) pe_cnt++;
      if (frameErr) begin
        fe_cnt++;
        fe_cyc = cyc;
      end
      if (keyValid && !kv_prev) begin
        kv_rise_cyc = cyc;
        kv_len = 0;
      end
      if (keyValid) kv_len++;
      kv_prev = keyValid;
      if (keyValid && keyReady) begin
        if (exp_q.size() == 0) check("unexpected_event", 32'(exp_q.size()), 32'd1);
        else check("event", 32'({keyExt, keyBreak, keyCode}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic model_frame(input logic [7:0] b, input bit good, input bit pop_same);
    if (!good) begin
      m_brk = 0;
      m_ext = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
`ifdef PS2_EXTENDED_EN
    end else if (b == 8'hE0) begin
      m_ext = 1;
`endif
    end else begin
      if (exp_q.size() >= FIFO_DEPTH && !pop_same) m_ovf = 1;
      else exp_q.push_back({m_ext, m_brk, b});
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  // drivers
  task automatic ps2_fall(input logic b);
    PS2Data = b;
    repeat (4) @(posedge clk);
    #1 PS2Clk = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic ps2_rise();
    repeat (8) @(posedge clk);
    #1 PS2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop, input bit pop_same);
    logic par;
    stop_seen = 0;
    par = ~(^b) ^ bad_par;
    ps2_fall(1'b0);
    ps2_rise();
    for (int i = 0; i < 8; i++) begin
      ps2_fall(b[i]);
      ps2_rise();
    end
    ps2_fall(par);
    ps2_rise();
    ps2_fall(stop);
    stop_seen = 1;
    model_frame(b, !bad_par && stop, pop_same);
    ps2_rise();
    PS2Data = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    m_brk = 0;
    m_ext = 0;
    m_ovf = 0;
  endtask

  int pe0, fe0;
  logic [7:0] part;

  initial begin
    reset    = 1'b1;
    PS2Clk   = 1'b1;
    PS2Data  = 1'b1;
    keyReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_keyValid",  32'(keyValid),  32'd0);
    check("rst_fifoCount", 32'(fifoCount), 32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_parityErr", 32'(parityErr), 32'd0);
    check("rst_frameErr",  32'(frameErr),  32'd0);
    check("rst_keyCode",   32'(keyCode),   32'd0);
    check("rst_keyBreak",  32'(keyBreak),  32'd0);
    check("rst_keyExt",    32'(keyExt),    32'd0);
    check("rst_state",     32'(dut.state), 32'd0);
    @(posedge clk);
    #1;

    // single make code: latency and one-cycle valid with keyReady high
    send_key(8'h1C);
    repeat (5) @(posedge clk);
    #1;
    check("latency", kv_rise_cyc - fall_cyc, 32'(SYNC_STAGES + 2));
    check("valid_width", 32'(kv_len), 32'd1);
    check("drain_make", 32'(exp_q.size()), 32'd0);

    // break prefix folds into the following code
    send_key(8'hF0);
    check("no_event_for_F0", 32'(fifoCount), 32'd0);
    send_key(8'h1C);
    repeat (5) @(posedge clk);
    #1;
    check("drain_break", 32'(exp_q.size()), 32'd0);

    // extended release sequence
    send_key(8'hE0);
    send_key(8'hF0);
    send_key(8'h75);
    repeat (5) @(posedge clk);
    #1;
    check("drain_ext", 32'(exp_q.size()), 32'd0);

    // bad parity drops frame and clears a pending break
    send_key(8'hF0);
    pe0 = pe_cnt;
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check("parity_pulse", 32'(pe_cnt - pe0), 32'd1);
    check("parity_no_frameErr", 32'(fe_cnt - fe0), 32'd0);
    check("parity_no_event", 32'(fifoCount), 32'd0);
    send_key(8'h32);
    repeat (5) @(posedge clk);
    #1;
    check("drain_after_parity", 32'(exp_q.size()), 32'd0);

    // bad stop bit, then both bad (parity wins)
    pe0 = pe_cnt;
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("stop_pulse", 32'(fe_cnt - fe0), 32'd1);
    check("stop_no_parityErr", 32'(pe_cnt - pe0), 32'd0);
    pe0 = pe_cnt;
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check("both_parityErr", 32'(pe_cnt - pe0), 32'd1);
    check("both_no_frameErr", 32'(fe_cnt - fe0), 32'd0);

    // timeout after four data bits, with a break prefix pending
    send_key(8'hF0);
    pe0 = pe_cnt;
    fe0 = fe_cnt;
    part = 8'h1C;
    ps2_fall(1'b0);
    ps2_rise();
    for (int i = 0; i < 4; i++) begin
      ps2_fall(part[i]);
      ps2_rise();
    end
    for (int i = 0; i < 300 && fe_cnt == fe0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    m_brk = 0;
    m_ext = 0;
    check("timeout_pulse", 32'(fe_cnt - fe0), 32'd1);
    check("timeout_cycle", fe_cyc - fall_cyc, 32'(TIMEOUT_CYCLES + SYNC_STAGES + 1));
    check("timeout_idle", 32'(dut.state), 32'd0);
    check("timeout_no_parityErr", 32'(pe_cnt - pe0), 32'd0);
    send_key(8'h1C);
    repeat (5) @(posedge clk);
    #1;
    check("drain_after_timeout", 32'(exp_q.size()), 32'd0);

    // overflow: five makes into a four-deep FIFO with no consumer
    keyReady = 1'b0;
    send_key(8'h15);
    send_key(8'h1D);
    send_key(8'h24);
    send_key(8'h2D);
    check("no_overflow_at_full", 32'(overflow), 32'd0);
    send_key(8'h2C);
    @(negedge clk);
    check("full_count", 32'(fifoCount), 32'(FIFO_DEPTH));
    check("overflow_set", 32'(overflow), 32'(m_ovf));
    check("full_valid", 32'(keyValid), 32'd1);
    check("full_head", 32'(keyCode), 32'h15);
    @(posedge clk);
    #1 keyReady = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("ovf_drain_valid", 32'(keyValid), 32'd0);
    check("ovf_drain_count", 32'(fifoCount), 32'd0);
    check("ovf_drain_queue", 32'(exp_q.size()), 32'd0);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // push and pop on the same cycle while full
    do_reset();
    @(negedge clk);
    check("overflow_cleared", 32'(overflow), 32'd0);
    @(posedge clk);
    #1 keyReady = 1'b0;
    send_key(8'h15);
    send_key(8'h1D);
    send_key(8'h24);
    send_key(8'h2D);
    stop_seen = 0;
    fork
      send_frame(8'h2C, 1'b0, 1'b1, 1'b1);
      begin
        wait (stop_seen);
        repeat (3) @(posedge clk);
        #1 keyReady = 1'b1;
        @(posedge clk);
        #1 keyReady = 1'b0;
      end
    join
    @(negedge clk);
    check("simul_count", 32'(fifoCount), 32'(FIFO_DEPTH));
    check("simul_no_overflow", 32'(overflow), 32'(m_ovf));
    check("simul_head", 32'(keyCode), 32'h1D);
    @(posedge clk);
    #1 keyReady = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("simul_drain_queue", 32'(exp_q.size()), 32'd0);
    check("simul_drain_valid", 32'(keyValid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
